// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the WB stage (A)
// and the multi-cycle unit (B). The grant is combinational and the write port is registered.
module regfile_wr_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              last_b,
  output logic [CNT_W-1:0]  wr_count
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              last_b_q, last_b_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;

  logic              grant_a, grant_b, granted, commit;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // On a tie, A wins only when B was the most recent grant.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset && !hold) begin
      grant_a = a_valid && (!b_valid || last_b_q);
      grant_b = b_valid && (!a_valid || !last_b_q);
    end
  end

  always_comb begin
    granted  = grant_a || grant_b;
    sel_addr = grant_b ? b_addr : a_addr;
    sel_data = grant_b ? b_data : a_data;
    // A zero-register write still completes its handshake, but it never enables the port.
    commit   = granted && (sel_addr != ZERO_ADDR);
  end

  always_comb begin
    wr_en_d    = commit;
    wr_addr_d  = granted ? sel_addr : wr_addr_q;
    wr_data_d  = granted ? sel_data : wr_data_q;
    last_b_d   = grant_b ? 1'b1 : (grant_a ? 1'b0 : last_b_q);
    wr_count_d = wr_count_q;
    if (commit && (wr_count_q != CNT_MAX)) begin
      wr_count_d = wr_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      last_b_q   <= 1'b1;
      wr_count_q <= '0;
    end else begin
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      last_b_q   <= last_b_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign a_ready  = grant_a;
  assign b_ready  = grant_b;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign last_b   = last_b_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter. A small counter width keeps the saturation check short.
module tb_regfile_wr_arbiter;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset, hold;
  logic              a_valid, b_valid;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_ready, b_ready, wr_en, last_b;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [CNT_W-1:0]  wr_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(31), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .last_b(last_b), .wr_count(wr_count)
  );

  typedef struct {
    logic              rst, hld;
    logic              av;
    logic [ADDR_W-1:0] aa;
    logic [DATA_W-1:0] ad;
    logic              bv;
    logic [ADDR_W-1:0] ba;
    logic [DATA_W-1:0] bd;
    logic              e_ar, e_br;
    logic              e_en;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    logic              e_lb;
    logic [CNT_W-1:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rst, hld,
    input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
    input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
    input logic e_ar, e_br, e_en, input logic [ADDR_W-1:0] e_addr,
    input logic [DATA_W-1:0] e_data, input logic e_lb, input logic [CNT_W-1:0] e_cnt);
    vec_t v;
    v.rst = rst; v.hld = hld; v.av = av; v.aa = aa; v.ad = ad;
    v.bv = bv; v.ba = ba; v.bd = bd; v.e_ar = e_ar; v.e_br = e_br;
    v.e_en = e_en; v.e_addr = e_addr; v.e_data = e_data; v.e_lb = e_lb; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; hold = v.hld;
    a_valid = v.av; a_addr = v.aa; a_data = v.ad;
    b_valid = v.bv; b_addr = v.ba; b_data = v.bd;
  endtask

  initial begin
    //            rst hld av aa  ad       bv ba  bd    ar br en addr data    lb cnt
    vecs.push_back(mk(1, 0, 1, 3, 64'h1,     0, 0,  0,    0, 0, 0, 0,  0,       1, 0));
    vecs.push_back(mk(0, 0, 1, 3, 64'hAAAA,  0, 0,  0,    1, 0, 1, 3,  64'hAAAA, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,         0, 0,  0,    0, 0, 0, 3,  64'hAAAA, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0,         0, 0,  0,    0, 0, 0, 0,  0,       1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 64'h11,    1, 2,  64'h22, 1, 0, 1, 1, 64'h11,  0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 64'h11,    1, 2,  64'h22, 0, 1, 1, 2, 64'h22,  1, 2));
    vecs.push_back(mk(0, 0, 1, 1, 64'h11,    1, 2,  64'h22, 1, 0, 1, 1, 64'h11,  0, 3));
    vecs.push_back(mk(0, 0, 1, 1, 64'h11,    1, 2,  64'h22, 0, 1, 1, 2, 64'h22,  1, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0,         1, 31, 64'h33, 0, 1, 0, 31, 64'h33, 1, 4));
    vecs.push_back(mk(0, 1, 1, 4, 64'h44,    1, 5,  64'h55, 0, 0, 0, 31, 64'h33, 1, 4));
    vecs.push_back(mk(0, 1, 1, 4, 64'h44,    1, 5,  64'h55, 0, 0, 0, 31, 64'h33, 1, 4));
    vecs.push_back(mk(0, 1, 1, 4, 64'h44,    1, 5,  64'h55, 0, 0, 0, 31, 64'h33, 1, 4));
    vecs.push_back(mk(0, 0, 1, 4, 64'h44,    1, 5,  64'h55, 1, 0, 1, 4,  64'h44, 0, 5));
    vecs.push_back(mk(0, 1, 0, 0, 0,         1, 5,  64'h55, 0, 0, 0, 4,  64'h44, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0,         1, 9,  64'h99, 0, 1, 1, 9,  64'h99, 1, 6));
    vecs.push_back(mk(0, 0, 1, 7, 64'h1,     1, 7,  64'h2,  1, 0, 1, 7,  64'h1,  0, 7));
    vecs.push_back(mk(0, 0, 0, 0, 0,         1, 7,  64'h2,  0, 1, 1, 7,  64'h2,  1, 8));
    vecs.push_back(mk(0, 0, 1, 6, 64'h66,    0, 0,  0,      1, 0, 1, 6,  64'h66, 0, 9));
    vecs.push_back(mk(1, 0, 1, 8, 64'h88,    1, 9,  64'h99, 0, 0, 0, 0,  0,      1, 0));
    vecs.push_back(mk(0, 0, 1, 31, 64'h77,   0, 0,  0,      1, 0, 0, 31, 64'h77, 0, 0));

    drive(vecs[0]);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      chk("a_ready", i, 64'(a_ready), 64'(vecs[i].e_ar));
      chk("b_ready", i, 64'(b_ready), 64'(vecs[i].e_br));
      @(posedge clk);
      #1;
      chk("wr_en",    i, 64'(wr_en),    64'(vecs[i].e_en));
      chk("wr_addr",  i, 64'(wr_addr),  64'(vecs[i].e_addr));
      chk("wr_data",  i, wr_data,       vecs[i].e_data);
      chk("last_b",   i, 64'(last_b),   64'(vecs[i].e_lb));
      chk("wr_count", i, 64'(wr_count), 64'(vecs[i].e_cnt));
      @(negedge clk);
    end

    // A write granted just before hold rises is still presented while hold is high.
    drive(mk(0, 0, 1, 10, 64'hBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    hold = 1'b1;
    #1;
    chk("hold_keeps_en",   100, 64'(wr_en),   64'd1);
    chk("hold_keeps_addr", 100, 64'(wr_addr), 64'd10);
    chk("hold_no_ready",   100, 64'(a_ready), 64'd0);
    @(posedge clk); #1;
    chk("hold_then_idle",  100, 64'(wr_en),   64'd0);
    chk("hold_cnt",        100, 64'(wr_count), 64'd1);

    // Counter saturation: 20 committed writes into a 4-bit counter.
    @(negedge clk);
    hold = 1'b0;
    for (int k = 0; k < 20; k++) begin
      a_valid = 1'b1; a_addr = 5'd12; a_data = 64'(k);
      @(posedge clk); #1;
      if (k == 13) chk("cnt_near_max", 101, 64'(wr_count), 64'd15);
      @(negedge clk);
    end
    chk("cnt_saturated", 102, 64'(wr_count), 64'd15);
    chk("sat_en",        102, 64'(wr_en),    64'd1);
    chk("sat_data",      102, wr_data,       64'd19);

    a_valid = 1'b0;
    @(posedge clk); #1;
    chk("sat_hold_cnt",  103, 64'(wr_count), 64'd15);
    chk("idle_en",       103, 64'(wr_en),    64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
